// File: rtl/msrv32_integer_file_pkg.sv
// msrv32_integer_file_pkg: shared integer-file sizing and the datapath word type
package msrv32_integer_file_pkg;
  localparam int XLEN = 32;
  localparam int REG_COUNT = 32;
  localparam int ADDR_W = 5;
  typedef logic [XLEN-1:0] xlen_t;
endpackage

// File: rtl/msrv32_integer_file.sv
// msrv32_integer_file: RV32I integer register file, two combinational read ports with write-through bypass
module msrv32_integer_file #(
  parameter int XLEN = msrv32_integer_file_pkg::XLEN,
  parameter int REG_COUNT = msrv32_integer_file_pkg::REG_COUNT,
  parameter int ADDR_W = msrv32_integer_file_pkg::ADDR_W
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [ADDR_W-1:0] rs_1_addr_in,
  input  logic [ADDR_W-1:0] rs_2_addr_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              wr_en_in,
  input  logic [XLEN-1:0]   rd_in,
  output logic [XLEN-1:0]   rs_1_out,
  output logic [XLEN-1:0]   rs_2_out
);
  logic [XLEN-1:0] regs_q [REG_COUNT];
  logic [REG_COUNT-1:0] we_d;
  logic wr_ok;
  // x0 is never a write target, so it keeps its reset value forever
  assign wr_ok = ms_riscv32_mp_rst_in && wr_en_in && rd_addr_in != '0;
  always_comb begin
    we_d = '0;
    for (int i = 1; i < REG_COUNT; i++) we_d[i] = wr_ok && rd_addr_in == ADDR_W'(i);
  end
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in)
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    else
      for (int i = 1; i < REG_COUNT; i++) if (we_d[i]) regs_q[i] <= rd_in;
  end
  assign rs_1_out = !ms_riscv32_mp_rst_in || rs_1_addr_in == '0 ? '0 :
                    wr_ok && rs_1_addr_in == rd_addr_in ? rd_in : regs_q[rs_1_addr_in];
  assign rs_2_out = !ms_riscv32_mp_rst_in || rs_2_addr_in == '0 ? '0 :
                    wr_ok && rs_2_addr_in == rd_addr_in ? rd_in : regs_q[rs_2_addr_in];
endmodule

// File: tb/tb_msrv32_integer_file.sv
// tb_msrv32_integer_file: scoreboard bench for the integer file against an array model
module tb_msrv32_integer_file;
  import msrv32_integer_file_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic [4:0] a1 = 0, a2 = 0, rd = 0;
  logic we = 0;
  xlen_t wd = 0;
  xlen_t r1, r2;
  typedef struct {
    string name;
    xlen_t e1;
    xlen_t e2;
  } exp_t;
  exp_t sb[$];
  xlen_t mdl [32];
  int checks = 0, fails = 0;

  msrv32_integer_file dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .rs_1_addr_in(a1),
    .rs_2_addr_in(a2),
    .rd_addr_in(rd),
    .wr_en_in(we),
    .rd_in(wd),
    .rs_1_out(r1),
    .rs_2_out(r2)
  );

  always #5 clk = ~clk;

  function automatic xlen_t expect_rd(input logic [4:0] a);
    if (!rst_n || a == 0) return 0;
    if (we && rd != 0 && rd == a) return wd;
    return mdl[a];
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks += 2;
      if (r1 !== e.e1) begin
        fails++;
        $display("FAIL %s rs_1_out: got %h want %h", e.name, r1, e.e1);
      end
      if (r2 !== e.e2) begin
        fails++;
        $display("FAIL %s rs_2_out: got %h want %h", e.name, r2, e.e2);
      end
    end
  end

  // Inputs change just after an edge; reset level is applied a little later so it can land mid-cycle.
  task automatic cyc(input string name, input logic r, input logic w, input logic [4:0] d,
                     input xlen_t v, input logic [4:0] x1, input logic [4:0] x2);
    exp_t e;
    we = w; rd = d; wd = v; a1 = x1; a2 = x2;
    #2 rst_n = r;
    if (!r) for (int i = 0; i < 32; i++) mdl[i] = 0;
    e.name = name;
    e.e1 = expect_rd(x1);
    e.e2 = expect_rd(x2);
    sb.push_back(e);
    @(posedge clk);
    if (rst_n && we && rd != 0) mdl[rd] = wd;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    @(posedge clk); #1;
    cyc("reset_state", 0, 1, 5, 32'h1234, 5, 0);
    cyc("reset_bypass_off", 0, 1, 9, 32'hdead, 9, 9);
    cyc("wr_x5", 1, 1, 5, 30, 1, 2);
    cyc("wr_x6", 1, 1, 6, 25, 5, 0);
    cyc("rd_6_5", 1, 0, 0, 0, 6, 5);
    cyc("bypass_x10", 1, 1, 10, 33, 10, 0);
    cyc("after_x10", 1, 0, 10, 0, 10, 0);
    cyc("wr_x0", 1, 1, 0, 32'hffffffff, 0, 0);
    cyc("rd_x0", 1, 0, 0, 0, 0, 0);
    cyc("we0_no_bypass", 1, 0, 3, 99, 3, 3);
    cyc("we0_no_change", 1, 0, 0, 0, 3, 3);
    cyc("wr_x7", 1, 1, 7, 32'ha5a5a5a5, 7, 6);
    cyc("x7_held", 1, 0, 0, 0, 7, 7);
    cyc("async_rst", 0, 0, 0, 0, 7, 5);
    cyc("x7_after_rst", 1, 0, 0, 0, 7, 5);
    cyc("old_on_diff", 1, 1, 8, 77, 7, 8);
    cyc("new_next_cyc", 1, 0, 0, 0, 8, 7);
    cyc("rst_wins_wr", 0, 1, 12, 55, 12, 8);
    cyc("rst_wins_after", 1, 0, 0, 0, 12, 8);
    cyc("first_wr_post_rst", 1, 1, 12, 66, 0, 12);
    cyc("first_wr_visible", 1, 0, 0, 0, 12, 0);
    for (int i = 1; i < 32; i++) cyc("sweep_wr", 1, 1, 5'(i), xlen_t'(i * 4 + 1), 5'(i), 5'(31 - i));
    for (int i = 0; i < 32; i++) cyc("sweep_rd", 1, 0, 5'(i), 32'hbad, 5'(i), 5'(31 - i));
    for (int n = 0; n < 400; n++) begin
      logic [4:0] d, x1, x2;
      d = 5'($urandom_range(0, 31));
      x1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      x2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      cyc("random", $urandom_range(0, 39) != 0, 1'($urandom), d, $urandom, x1, x2);
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1, "watchdog");
  end
endmodule
